// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the OAM DMA engine, the CPU/memory side and the PPU OAM port.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  mem_rdata;
  logic        oam_dma;
  logic [15:0] dma_addr;
  logic        dma_re;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_in;
  logic        oam_we;
  logic        dma_done;

  // Strobe semantics: cpu_we qualifies cpu_addr/cpu_wdata in the same cycle, dma_re
  // qualifies dma_addr and mem_rdata answers one cycle later, oam_we qualifies
  // oam_addr/oam_data_in; there is no back-pressure on any of these transfers.
  modport master (
    output cpu_addr, cpu_we, cpu_wdata, mem_rdata,
    input  oam_dma, dma_addr, dma_re, oam_addr, oam_data_in, oam_we, dma_done
  );

  modport slave (
    input  cpu_addr, cpu_we, cpu_wdata, mem_rdata,
    output oam_dma, dma_addr, dma_re, oam_addr, oam_data_in, oam_we, dma_done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA engine: a CPU write to REG_ADDR halts the CPU and copies one
// page of CPU space into PPU OAM, alternating read and write cycles.
module oam_dma_ctrl #(
  parameter logic [15:0] REG_ADDR = 16'h4014,
  parameter int unsigned XFER_LEN = 256
) (
  input  logic           clk,
  input  logic           reset,
  oam_dma_ctrl_if.slave  bus,
  output logic [2:0]     state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state;
  logic [7:0] page;
  logic [7:0] idx;
  logic       cycle_odd;
  logic       done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      page      <= 8'h00;
      idx       <= 8'h00;
      cycle_odd <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cycle_odd <= ~cycle_odd;
      done_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_we && (bus.cpu_addr == REG_ADDR)) begin
            page  <= bus.cpu_wdata;
            idx   <= 8'h00;
            state <= HALT;
          end
        end
        // An extra cycle is spent when the halt lands on an odd cycle so reads start aligned.
        HALT:  state <= cycle_odd ? ALIGN : READ;
        ALIGN: state <= READ;
        READ:  state <= WRITE;
        WRITE: begin
          if (idx != LAST_IDX) begin
            idx   <= idx + 8'd1;
            state <= READ;
          end else begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // idx is only 8 bits, so {page, idx} can never leave the latched page.
  assign bus.oam_dma     = (state != IDLE);
  assign bus.dma_re      = (state == READ);
  assign bus.dma_addr    = (state == READ) ? {page, idx} : 16'h0000;
  assign bus.oam_we      = (state == WRITE);
  assign bus.oam_addr    = (state == WRITE) ? idx : 8'h00;
  assign bus.oam_data_in = (state == WRITE) ? bus.mem_rdata : 8'h00;
  assign bus.dma_done    = done_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: memory model, OAM write/read scoreboard and scenario tasks.
module tb_oam_dma_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] state_dbg;

  oam_dma_ctrl_if bus ();

  oam_dma_ctrl #(.REG_ADDR(16'h4014), .XFER_LEN(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int passes = 0;
  int hi_cnt, we_cnt, rd_cnt, done_cnt;
  int first_rd_cyc, write_cyc;
  int cyc = 0;
  logic [15:0] last_rd_addr;
  bit saw_zero, align_seen;
  logic phase;
  logic [15:0] exp_q[$];
  logic [15:0] exp_rd_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) phase <= reset ? 1'b0 : ~phase;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return (a[7:0] ^ a[15:8]) + 8'h3C;
  endfunction

  // CPU-space memory answers one cycle after the read strobe.
  always @(posedge clk) bus.mem_rdata <= bus.dma_re ? mem_byte(bus.dma_addr) : 8'h00;

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (bus.oam_dma) hi_cnt++;
    if (bus.dma_done) done_cnt++;
    if (state_dbg == 3'd2) align_seen = 1'b1;
    checks++;
    if (bus.dma_re) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      last_rd_addr = bus.dma_addr;
      if (bus.dma_addr == 16'h0000) saw_zero = 1'b1;
      if (exp_rd_q.size() == 0) begin
        $display("FAIL rd_unexpected: dma_addr=%h, required no read", bus.dma_addr);
      end else begin
        e = exp_rd_q.pop_front();
        if (bus.dma_addr !== e) $display("FAIL rd_addr: got %h, expected %h", bus.dma_addr, e);
        else passes++;
      end
    end else begin
      if (bus.dma_addr !== 16'h0000) $display("FAIL rd_addr_idle: got %h, expected 0000", bus.dma_addr);
      else passes++;
    end
    checks++;
    if (bus.oam_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL oam_unexpected: addr=%h data=%h, required no write", bus.oam_addr, bus.oam_data_in);
      end else begin
        e = exp_q.pop_front();
        if ({bus.oam_addr, bus.oam_data_in} !== e)
          $display("FAIL oam_write: got addr/data %h, expected %h", {bus.oam_addr, bus.oam_data_in}, e);
        else passes++;
      end
    end else begin
      if ({bus.oam_addr, bus.oam_data_in} !== 16'h0000)
        $display("FAIL oam_idle: got addr/data %h, expected 0000", {bus.oam_addr, bus.oam_data_in});
      else passes++;
    end
  end

  task automatic clear_counters();
    hi_cnt = 0; we_cnt = 0; rd_cnt = 0; done_cnt = 0;
    first_rd_cyc = -1; saw_zero = 1'b0; align_seen = 1'b0;
  endtask

  // halt_odd < 0 writes on the very next cycle whatever its parity.
  task automatic run_dma(input logic [7:0] page, input int halt_odd, input int inj_idx,
                         input int rst_idx, output bit timed_out, output bit halt_was_odd);
    @(negedge clk);
    if (halt_odd >= 0 && phase == halt_odd[0]) @(negedge clk);
    halt_was_odd = ~phase;
    for (int n = 0; n < 256; n++) begin
      exp_q.push_back({8'(n), mem_byte({page, 8'(n)})});
      exp_rd_q.push_back({page, 8'(n)});
    end
    clear_counters();
    write_cyc = cyc;
    bus.cpu_addr = 16'h4014; bus.cpu_wdata = page; bus.cpu_we = 1'b1;
    timed_out = 1'b1;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      bus.cpu_we = 1'b0;
      if (bus.dma_done) begin timed_out = 1'b0; break; end
      if (bus.dma_re && inj_idx >= 0 && bus.dma_addr[7:0] == inj_idx[7:0]) begin
        bus.cpu_addr = 16'h4014; bus.cpu_wdata = 8'h07; bus.cpu_we = 1'b1;
      end
      if (bus.dma_re && rst_idx >= 0 && bus.dma_addr[7:0] == rst_idx[7:0]) begin
        reset = 1'b1; timed_out = 1'b0; break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_counters();
    repeat (10) @(negedge clk);
    checks++; if (hi_cnt !== 0) $display("FAIL reset_oam_dma: got %0d high cycles, expected 0", hi_cnt); else passes++;
    checks++; if (rd_cnt !== 0) $display("FAIL reset_reads: got %0d, expected 0", rd_cnt); else passes++;
    checks++; if (we_cnt !== 0) $display("FAIL reset_writes: got %0d, expected 0", we_cnt); else passes++;
    checks++; if (done_cnt !== 0) $display("FAIL reset_done: got %0d, expected 0", done_cnt); else passes++;
    checks++; if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d, expected 0", state_dbg); else passes++;
  endtask

  task automatic test_other_addr();
    @(negedge clk);
    clear_counters();
    bus.cpu_addr = 16'h4015; bus.cpu_wdata = 8'h02; bus.cpu_we = 1'b1;
    @(negedge clk);
    bus.cpu_we = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (hi_cnt !== 0) $display("FAIL other_addr: got %0d high cycles, expected 0", hi_cnt); else passes++;
  endtask

  task automatic test_even();
    bit to, ho;
    run_dma(8'h02, 0, -1, -1, to, ho);
    repeat (3) @(negedge clk);
    checks++; if (to !== 1'b0) $display("FAIL even_timeout: got timeout, expected dma_done"); else passes++;
    checks++; if (first_rd_cyc - write_cyc !== 2) $display("FAIL even_latency: got %0d, expected 2", first_rd_cyc - write_cyc); else passes++;
    checks++; if (hi_cnt !== 513) $display("FAIL even_oam_dma: got %0d, expected 513", hi_cnt); else passes++;
    checks++; if (we_cnt !== 256) $display("FAIL even_writes: got %0d, expected 256", we_cnt); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL even_done: got %0d, expected 1", done_cnt); else passes++;
    checks++; if (align_seen !== 1'b0) $display("FAIL even_align: got ALIGN, expected none"); else passes++;
    checks++; if (exp_q.size() !== 0) $display("FAIL even_left: got %0d pending, expected 0", exp_q.size()); else passes++;
  endtask

  task automatic test_odd();
    bit to, ho;
    run_dma(8'h02, 1, -1, -1, to, ho);
    repeat (3) @(negedge clk);
    checks++; if (to !== 1'b0) $display("FAIL odd_timeout: got timeout, expected dma_done"); else passes++;
    checks++; if (first_rd_cyc - write_cyc !== 3) $display("FAIL odd_latency: got %0d, expected 3", first_rd_cyc - write_cyc); else passes++;
    checks++; if (hi_cnt !== 514) $display("FAIL odd_oam_dma: got %0d, expected 514", hi_cnt); else passes++;
    checks++; if (align_seen !== 1'b1) $display("FAIL odd_align: got none, expected ALIGN"); else passes++;
    checks++; if (we_cnt !== 256) $display("FAIL odd_writes: got %0d, expected 256", we_cnt); else passes++;
  endtask

  task automatic test_page_ff();
    bit to, ho;
    run_dma(8'hFF, 0, -1, -1, to, ho);
    repeat (3) @(negedge clk);
    checks++; if (to !== 1'b0) $display("FAIL ff_timeout: got timeout, expected dma_done"); else passes++;
    checks++; if (last_rd_addr !== 16'hFFFF) $display("FAIL ff_last_read: got %h, expected ffff", last_rd_addr); else passes++;
    checks++; if (saw_zero !== 1'b0) $display("FAIL ff_wrap: got read at 0000, expected none"); else passes++;
    checks++; if (rd_cnt !== 256) $display("FAIL ff_reads: got %0d, expected 256", rd_cnt); else passes++;
  endtask

  task automatic test_ignore_rewrite();
    bit to, ho;
    run_dma(8'h02, 0, 100, -1, to, ho);
    repeat (3) @(negedge clk);
    checks++; if (to !== 1'b0) $display("FAIL rewrite_timeout: got timeout, expected dma_done"); else passes++;
    checks++; if (we_cnt !== 256) $display("FAIL rewrite_writes: got %0d, expected 256", we_cnt); else passes++;
    checks++; if (hi_cnt !== 513) $display("FAIL rewrite_oam_dma: got %0d, expected 513", hi_cnt); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL rewrite_done: got %0d, expected 1", done_cnt); else passes++;
  endtask

  task automatic test_reset_mid();
    bit to, ho;
    run_dma(8'h02, 0, -1, 50, to, ho);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.oam_dma !== 1'b0) $display("FAIL abort_oam_dma: got %b, expected 0", bus.oam_dma); else passes++;
    checks++; if (bus.oam_we !== 1'b0) $display("FAIL abort_oam_we: got %b, expected 0", bus.oam_we); else passes++;
    exp_q.delete();
    exp_rd_q.delete();
    repeat (4) @(negedge clk);
    checks++; if (we_cnt !== 50) $display("FAIL abort_writes: got %0d, expected 50", we_cnt); else passes++;
    checks++; if (done_cnt !== 0) $display("FAIL abort_done: got %0d, expected 0", done_cnt); else passes++;
    run_dma(8'h11, 0, -1, -1, to, ho);
    repeat (3) @(negedge clk);
    checks++; if (to !== 1'b0) $display("FAIL restart_timeout: got timeout, expected dma_done"); else passes++;
    checks++; if (we_cnt !== 256) $display("FAIL restart_writes: got %0d, expected 256", we_cnt); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL restart_done: got %0d, expected 1", done_cnt); else passes++;
  endtask

  task automatic test_back_to_back();
    bit to1, to2, ho1, ho2;
    int w1;
    run_dma(8'h02, 0, -1, -1, to1, ho1);
    w1 = we_cnt;
    run_dma(8'h03, -1, -1, -1, to2, ho2);
    repeat (3) @(negedge clk);
    checks++; if (to1 !== 1'b0) $display("FAIL b2b_first_timeout: got timeout, expected dma_done"); else passes++;
    checks++; if (w1 !== 256) $display("FAIL b2b_first_writes: got %0d, expected 256", w1); else passes++;
    checks++; if (to2 !== 1'b0) $display("FAIL b2b_second_timeout: got timeout, expected dma_done"); else passes++;
    checks++;
    if (first_rd_cyc - write_cyc !== 2 + int'(ho2))
      $display("FAIL b2b_latency: got %0d, expected %0d", first_rd_cyc - write_cyc, 2 + int'(ho2));
    else passes++;
    checks++;
    if (hi_cnt !== 513 + int'(ho2)) $display("FAIL b2b_oam_dma: got %0d, expected %0d", hi_cnt, 513 + int'(ho2));
    else passes++;
    checks++; if (we_cnt !== 256) $display("FAIL b2b_writes: got %0d, expected 256", we_cnt); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL b2b_done: got %0d, expected 1", done_cnt); else passes++;
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'h0000;
    bus.cpu_wdata = 8'h00;
    clear_counters();
    test_reset();
    test_other_addr();
    test_even();
    test_odd();
    test_page_ff();
    test_ignore_rewrite();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
